// File: rtl/tcp_pkg.sv
// Shared TCP RX types: parser states, header field layout, flag bit positions
// and a 16-bit ones-complement adder used by the checksum path.
package tcp_pkg;

   localparam int TCP_HDR_MIN_BYTES = 20;

   typedef enum int {
      FLAG_FIN = 0,
      FLAG_SYN = 1,
      FLAG_RST = 2,
      FLAG_PSH = 3,
      FLAG_ACK = 4
   } tcp_flag_e;

   typedef enum logic [1:0] {
      S_HDR,
      S_SYNC,
      S_PAYLOAD,
      S_DROP
   } state_t;

   typedef struct packed {
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [31:0] seq;
      logic [31:0] ack;
      logic [3:0]  doff;
      logic [7:0]  flags;
      logic [15:0] window;
   } tcp_hdr_t;

   // End-around-carry add; a+b <= 0x1FFFE so the second add cannot carry again.
   function automatic logic [15:0] oc_add16(input logic [15:0] a, input logic [15:0] b);
      logic [16:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[15:0] + {15'd0, s[16]};
   endfunction

endpackage

// File: rtl/tcp_csum_acc.sv
// Byte-serial ones-complement accumulator for the TCP checksum; only built when
// TCP_RX_CKSUM_EN is defined. Clears itself on the last byte of each segment.
module tcp_csum_acc
   import tcp_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        add,
   input  logic        last,
   input  logic [7:0]  data,
   input  logic [15:0] pseudo_sum,
   output logic [15:0] sum_final
);

   logic [15:0] sum_r;
   logic [15:0] len_r;
   logic [15:0] word;
   logic [15:0] sum_add;

   // Even byte offsets are the high half of a big-endian word; a trailing odd
   // byte therefore lands as {byte, 8'h00}, which is the required zero padding.
   always_comb begin
      word      = len_r[0] ? {8'h00, data} : {data, 8'h00};
      sum_add   = oc_add16(sum_r, word);
      sum_final = oc_add16(oc_add16(sum_add, pseudo_sum), len_r + 16'd1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r <= '0;
         len_r <= '0;
      end else if (add) begin
         if (last) begin
            sum_r <= '0;
            len_r <= '0;
         end else begin
            sum_r <= sum_add;
            len_r <= len_r + 16'd1;
         end
      end
   end

endmodule

// File: rtl/tcp_rx_parser.sv
// TCP RX parser: strips the header and options, filters on destination port and
// passes payload through with a per-segment seq tag. Optional: TCP_RX_CKSUM_EN.
module tcp_rx_parser
   import tcp_pkg::*;
#(
   parameter int          DATA_WIDTH = 8,
   parameter int          SEQ_BITS   = 32,
   parameter logic [15:0] LOCAL_PORT = 16'd5000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [SEQ_BITS-1:0]   seq_start,
   output logic [SEQ_BITS-1:0]   seq_base,
   output logic                  base_valid,
   output logic                  hdr_valid,
   output logic [31:0]           hdr_ack,
   output logic [7:0]            hdr_flags,
   output logic [15:0]           hdr_window,
   input  logic [15:0]           pseudo_sum,
   output logic                  cksum_err,
   output logic [15:0]           drop_cnt
);

   state_t     state, state_nx;
   logic [5:0] cnt;
   tcp_hdr_t   hdr_r;
   logic [5:0] hdr_last_idx;
   logic       hdr_end, hdr_ok, hdr_pass, hdr_fail, trunc, syn, accept;
   logic       unused_src;

   assign unused_src = ^hdr_r.src_port;

   // doff is only trusted once byte 12 has passed; the last index is always
   // >= 19, so a stale doff from the previous segment can never match early.
   always_comb begin
      hdr_last_idx = (hdr_r.doff < 4'd5) ? 6'(TCP_HDR_MIN_BYTES - 1)
                                         : {hdr_r.doff - 4'd1, 2'b11};
      hdr_ok   = (hdr_r.doff >= 4'd5) && (hdr_r.dst_port == LOCAL_PORT);
      hdr_end  = (state == S_HDR) && s_axis_tvalid && (cnt == hdr_last_idx);
      hdr_pass = hdr_end && hdr_ok;
      hdr_fail = hdr_end && !hdr_ok;
      trunc    = (state == S_HDR) && s_axis_tvalid && s_axis_tlast && !hdr_end;
      syn      = hdr_r.flags[FLAG_SYN];
   end

   // NOTE: every combinational output gets a default first so no path through
   // the case statement can infer a latch.
   always_comb begin
      state_nx      = state;
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tlast  = 1'b0;
      case (state)
         S_HDR: begin
            s_axis_tready = 1'b1;
            if (hdr_end)
               state_nx = s_axis_tlast ? S_HDR : (hdr_ok ? S_SYNC : S_DROP);
         end
         S_SYNC: state_nx = S_PAYLOAD;
         S_PAYLOAD: begin
            s_axis_tready = m_axis_tready;
            m_axis_tvalid = s_axis_tvalid;
            m_axis_tdata  = s_axis_tdata;
            m_axis_tlast  = s_axis_tlast;
            if (s_axis_tvalid && m_axis_tready && s_axis_tlast)
               state_nx = S_HDR;
         end
         S_DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast)
               state_nx = S_HDR;
         end
         default: state_nx = S_HDR;
      endcase
   end

   assign accept = s_axis_tvalid & s_axis_tready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_HDR;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         hdr_r      <= '0;
         hdr_valid  <= 1'b0;
         base_valid <= 1'b0;
         hdr_ack    <= '0;
         hdr_flags  <= '0;
         hdr_window <= '0;
         seq_start  <= '0;
         seq_base   <= '0;
         drop_cnt   <= '0;
      end else begin
         if (state == S_HDR && s_axis_tvalid) begin
            cnt <= (s_axis_tlast || hdr_end) ? 6'd0 : cnt + 6'd1;
            case (cnt)
               6'd0, 6'd1:             hdr_r.src_port <= {hdr_r.src_port[7:0], s_axis_tdata};
               6'd2, 6'd3:             hdr_r.dst_port <= {hdr_r.dst_port[7:0], s_axis_tdata};
               6'd4, 6'd5, 6'd6, 6'd7: hdr_r.seq      <= {hdr_r.seq[23:0], s_axis_tdata};
               6'd8, 6'd9, 6'd10, 6'd11: hdr_r.ack    <= {hdr_r.ack[23:0], s_axis_tdata};
               6'd12:                  hdr_r.doff     <= s_axis_tdata[7:4];
               6'd13:                  hdr_r.flags    <= s_axis_tdata;
               6'd14, 6'd15:           hdr_r.window   <= {hdr_r.window[7:0], s_axis_tdata};
               default: ;
            endcase
         end

         hdr_valid  <= hdr_pass;
         base_valid <= hdr_pass && syn;
         if (hdr_pass) begin
            hdr_ack    <= hdr_r.ack;
            hdr_flags  <= hdr_r.flags;
            hdr_window <= hdr_r.window;
            seq_start  <= hdr_r.seq[SEQ_BITS-1:0] + SEQ_BITS'(syn);
            if (syn)
               seq_base <= hdr_r.seq[SEQ_BITS-1:0] + SEQ_BITS'(1);
         end

         if ((hdr_fail || trunc) && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

`ifdef TCP_RX_CKSUM_EN
   logic [15:0] sum_final;
   logic        cksum_chk;

   tcp_csum_acc u_csum (
      .clk        (clk),
      .rst_n      (rst_n),
      .add        (accept),
      .last       (s_axis_tlast),
      .data       (s_axis_tdata),
      .pseudo_sum (pseudo_sum),
      .sum_final  (sum_final)
   );

   // Only segments that were actually forwarded may flag a checksum error.
   assign cksum_chk = accept && s_axis_tlast && ((state == S_PAYLOAD) || hdr_pass);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cksum_err <= 1'b0;
      else        cksum_err <= cksum_chk && (sum_final != 16'hFFFF);
   end
`else
   logic unused_cksum;

   assign unused_cksum = ^pseudo_sum ^ accept;
   assign cksum_err    = 1'b0;
`endif

endmodule

// File: tb/tb_tcp_rx_parser.sv
// Scoreboard bench for tcp_rx_parser: a segment-level reference model queues
// expected header events and payload beats; a negedge monitor pops and compares.
module tb_tcp_rx_parser;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready = 1'b1;
   logic        m_axis_tlast;
   logic [31:0] seq_start, seq_base;
   logic        base_valid, hdr_valid;
   logic [31:0] hdr_ack;
   logic [7:0]  hdr_flags;
   logic [15:0] hdr_window;
   logic [15:0] pseudo_sum = '0;
   logic        cksum_err;
   logic [15:0] drop_cnt;

   tcp_rx_parser dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast),
      .seq_start     (seq_start),
      .seq_base      (seq_base),
      .base_valid    (base_valid),
      .hdr_valid     (hdr_valid),
      .hdr_ack       (hdr_ack),
      .hdr_flags     (hdr_flags),
      .hdr_window    (hdr_window),
      .pseudo_sum    (pseudo_sum),
      .cksum_err     (cksum_err),
      .drop_cnt      (drop_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  d;
      logic        last;
      logic [31:0] seq;
   } beat_t;

   typedef struct {
      logic [31:0] ack;
      logic [7:0]  flags;
      logic [15:0] win;
      logic [31:0] seq_start;
      logic        syn;
      logic [31:0] base;
      logic        has_pay;
   } exp_hdr_t;

   beat_t      pay_q[$];
   exp_hdr_t   hdr_q[$];
   logic [7:0] seg[$];
   int         errors = 0;
   int         checks = 0;
   int         exp_drops = 0;
   int         err_pend = 0;
   longint     cyc = 0;
   longint     last_tlast_cyc = 0;
   logic [15:0] cur_pseudo = '0;
   bit         gap_en = 1'b1;
   bit         stall_en = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic finish_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   // Sum of big-endian 16-bit words (odd tail padded), pseudo header and length.
   function automatic logic [15:0] ones_sum(input logic [15:0] pseudo);
      logic [31:0] s;
      int n;
      s = 0;
      n = seg.size();
      for (int i = 0; i < n; i += 2)
         s += {16'd0, seg[i], (i + 1 < n) ? seg[i+1] : 8'h00};
      s += {16'd0, pseudo};
      s += 32'(n);
      while (s[31:16] != 0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      return s[15:0];
   endfunction

   task automatic build(input logic [15:0] dst, input logic [31:0] seq, input logic [31:0] ack,
                        input logic [3:0] doff, input logic [7:0] flags, input logic [15:0] win,
                        input int pay_len);
      logic [15:0] src;
      logic [15:0] ck;
      int hl;
      src = 16'($urandom);
      cur_pseudo = 16'($urandom);
      hl = (doff < 5) ? 20 : 4 * int'(doff);
      seg.delete();
      seg.push_back(src[15:8]); seg.push_back(src[7:0]);
      seg.push_back(dst[15:8]); seg.push_back(dst[7:0]);
      for (int i = 3; i >= 0; i--) seg.push_back(seq[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) seg.push_back(ack[i*8 +: 8]);
      seg.push_back({doff, 4'h0});
      seg.push_back(flags);
      seg.push_back(win[15:8]); seg.push_back(win[7:0]);
      while (seg.size() < hl) seg.push_back(8'($urandom));
      for (int i = 0; i < pay_len; i++) seg.push_back(8'($urandom));
      seg[16] = 8'h00;
      seg[17] = 8'h00;
      ck = ~ones_sum(cur_pseudo);
      seg[16] = ck[15:8];
      seg[17] = ck[7:0];
   endtask

   // Reference model: decides the fate of a whole segment from the header rules.
   task automatic model_seg();
      int n, doff, hl;
      logic [7:0] b12;
      logic [31:0] seq;
      exp_hdr_t h;
      beat_t b;
      n = seg.size();
      b12 = (n > 12) ? seg[12] : 8'h00;
      doff = int'(b12[7:4]);
      hl = (doff < 5) ? 20 : 4 * doff;
      if (n < hl || doff < 5 || {seg[2], seg[3]} != 16'd5000) begin
         exp_drops++;
         return;
      end
      seq       = {seg[4], seg[5], seg[6], seg[7]};
      h.ack     = {seg[8], seg[9], seg[10], seg[11]};
      h.flags   = seg[13];
      h.win     = {seg[14], seg[15]};
      h.syn     = h.flags[1];
      h.seq_start = seq + 32'(h.syn);
      h.base    = seq + 32'd1;
      h.has_pay = (n > hl);
      hdr_q.push_back(h);
      for (int i = hl; i < n; i++) begin
         b.d = seg[i];
         b.last = (i == n - 1);
         b.seq = h.seq_start;
         pay_q.push_back(b);
      end
`ifdef TCP_RX_CKSUM_EN
      if (ones_sum(cur_pseudo) != 16'hFFFF) err_pend++;
`endif
   endtask

   task automatic send_seg();
      bit ok;
      int w;
      pseudo_sum = cur_pseudo;
      for (int i = 0; i < seg.size(); i++) begin
         if (gap_en && $urandom_range(0, 3) == 0) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
            @(posedge clk); #1;
         end
         s_axis_tdata  = seg[i];
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = (i == seg.size() - 1);
         w = 0;
         do begin
            @(negedge clk);
            ok = s_axis_tready;
            @(posedge clk); #1;
            w++;
         end while (!ok && w < 1000);
         if (!ok) begin
            check("send_accept_timeout", 64'(ok), 64'd1);
            finish_run();
         end
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic run_seg();
      model_seg();
      send_seg();
   endtask

   task automatic drain();
      int w;
      w = 0;
      while ((pay_q.size() != 0 || hdr_q.size() != 0 || err_pend != 0) && w < 300) begin
         @(posedge clk); #1;
         w++;
      end
      repeat (3) begin @(posedge clk); #1; end
      check("drain_payload_left", 64'(pay_q.size()), 64'd0);
      check("drain_hdr_left", 64'(hdr_q.size()), 64'd0);
      check("drain_cksum_err_left", 64'(err_pend), 64'd0);
      check("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
      check("cksum_err_idle", 64'(cksum_err), 64'd0);
   endtask

   always begin
      @(posedge clk); #1;
      m_axis_tready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   always @(negedge clk) begin
      beat_t    b;
      exp_hdr_t h;
      if (rst_n) begin
         if (m_axis_tvalid && m_axis_tready) begin
            check("unexpected_beat", 64'(pay_q.size() == 0), 64'd0);
            if (pay_q.size() != 0) begin
               b = pay_q.pop_front();
               check("pay_data", 64'(m_axis_tdata), 64'(b.d));
               check("pay_last", 64'(m_axis_tlast), 64'(b.last));
               check("pay_seq_start", 64'(seq_start), 64'(b.seq));
            end
         end
         if (hdr_valid) begin
            check("unexpected_hdr_valid", 64'(hdr_q.size() == 0), 64'd0);
            if (hdr_q.size() != 0) begin
               h = hdr_q.pop_front();
               check("hdr_ack", 64'(hdr_ack), 64'(h.ack));
               check("hdr_flags", 64'(hdr_flags), 64'(h.flags));
               check("hdr_window", 64'(hdr_window), 64'(h.win));
               check("seq_start", 64'(seq_start), 64'(h.seq_start));
               check("base_valid", 64'(base_valid), 64'(h.syn));
               if (h.syn) check("seq_base", 64'(seq_base), 64'(h.base));
               check("sync_no_beat", 64'(m_axis_tvalid), 64'd0);
               if (h.has_pay) check("sync_no_ready", 64'(s_axis_tready), 64'd0);
               check("cksum_err_at_hdr", 64'(cksum_err), 64'd0);
            end
         end
         if (base_valid) check("base_without_hdr", 64'(hdr_valid), 64'd1);
`ifdef TCP_RX_CKSUM_EN
         if (cksum_err) begin
            check("cksum_err_expected", 64'(err_pend > 0), 64'd1);
            if (err_pend > 0) err_pend--;
            check("cksum_err_timing", 64'(cyc), 64'(last_tlast_cyc + 1));
         end
`endif
         if (s_axis_tvalid && s_axis_tready && s_axis_tlast) last_tlast_cyc = cyc;
      end
   end

   initial begin
      #900000;
      errors++;
      checks++;
      $display("FAIL watchdog: simulation did not complete in time");
      finish_run();
   end

   initial begin
      logic [15:0] dst;
      logic [3:0]  doff;
      int          pay, cut;

      repeat (2) @(negedge clk);
      check("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("rst_hdr_valid", 64'(hdr_valid), 64'd0);
      check("rst_base_valid", 64'(base_valid), 64'd0);
      check("rst_seq_start", 64'(seq_start), 64'd0);
      check("rst_seq_base", 64'(seq_base), 64'd0);
      check("rst_hdr_ack", 64'(hdr_ack), 64'd0);
      check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      check("rst_cksum_err", 64'(cksum_err), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // ACK segment with fixed 4-byte payload.
      build(16'd5000, 32'h0000_1000, 32'h1122_3344, 4'd5, 8'h10, 16'h2000, 4);
      seg[20] = 8'hDE; seg[21] = 8'hAD; seg[22] = 8'hBE; seg[23] = 8'hEF;
      seg[16] = 8'h00; seg[17] = 8'h00;
      begin
         logic [15:0] ck;
         ck = ~ones_sum(cur_pseudo);
         seg[16] = ck[15:8];
         seg[17] = ck[7:0];
      end
      run_seg();
      drain();

      // SYN at the top of sequence space, no payload.
      build(16'd5000, 32'hFFFF_FFFF, 32'h0, 4'd5, 8'h02, 16'hFFFF, 0);
      run_seg();
      drain();

      // Options skipped, 3-byte payload.
      build(16'd5000, 32'hABCD_0001, 32'h5, 4'd7, 8'h18, 16'h0100, 3);
      run_seg();
      drain();

      // Wrong port dropped, then a good segment back-to-back.
      gap_en = 1'b0;
      build(16'd80, 32'h10, 32'h20, 4'd5, 8'h18, 16'h1, 10);
      run_seg();
      build(16'd5000, 32'h7777_0000, 32'h9, 4'd6, 8'h18, 16'h2, 5);
      run_seg();
      drain();
      gap_en = 1'b1;

      // Truncated header: tlast on byte 9.
      build(16'd5000, 32'h1, 32'h2, 4'd5, 8'h10, 16'h3, 0);
      while (seg.size() > 10) seg.delete(seg.size() - 1);
      run_seg();
      drain();

      // 100-byte payload under random downstream backpressure.
      stall_en = 1'b1;
      build(16'd5000, 32'h0BAD_F00D, 32'h4, 4'd5, 8'h18, 16'h4, 100);
      run_seg();
      drain();
      stall_en = 1'b0;

`ifdef TCP_RX_CKSUM_EN
      build(16'd5000, 32'h100, 32'h200, 4'd5, 8'h18, 16'h5, 6);
      run_seg();
      drain();
      build(16'd5000, 32'h100, 32'h200, 4'd5, 8'h18, 16'h5, 6);
      seg[22] = seg[22] ^ 8'h04;
      run_seg();
      drain();
`endif

      // Randomised segments: ports, option lengths, flags, truncation, stalls.
      for (int k = 0; k < 40; k++) begin
         dst  = ($urandom_range(0, 4) == 0) ? 16'd80 : 16'd5000;
         doff = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(5, 15));
         pay  = $urandom_range(0, 40);
         build(dst, $urandom, $urandom, doff, 8'($urandom), 16'($urandom), pay);
         if ($urandom_range(0, 7) == 0) begin
            cut = $urandom_range(1, seg.size() - 1);
            while (seg.size() > cut) seg.delete(seg.size() - 1);
         end
         if ($urandom_range(0, 7) == 0 && seg.size() > 20)
            seg[seg.size() - 1] = seg[seg.size() - 1] ^ 8'h80;
         stall_en = 1'($urandom_range(0, 1));
         gap_en   = 1'($urandom_range(0, 1));
         run_seg();
         if ($urandom_range(0, 1) == 0) drain();
      end
      stall_en = 1'b0;
      drain();

      finish_run();
   end

endmodule
